// File: rtl/dphy_pkg.sv
// Shared types and constants for the D-PHY receive data lane.
package dphy_pkg;

  // Lane protocol states as seen by the receiver.
  typedef enum logic [2:0] {
    StStop,
    StHsRqst,
    StBridge,
    StSync,
    StHs,
    StWaitStop
  } lane_state_e;

  // LP line codes, {lp_p, lp_n}.
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [1:0] LP10 = 2'b10;

  // Leader sequence 00011101 received LSB-first lands in the word as 0xB8.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hB8;

endpackage

// File: rtl/dphy_rx_align.sv
// Sync search and bit alignment over a two-word sliding window of raw HS words.
module dphy_rx_align
  import dphy_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic       byte_clk,
  input  logic       byte_rst,
  input  logic [7:0] hs_data,
  input  logic       offset_load,
  output logic       sync_found,
  output logic [7:0] aligned
);

  logic [7:0]  hs_prev_q;
  logic [2:0]  offset_q;
  logic [2:0]  match_off;
  logic [15:0] window;
  logic [15:0] shifted;

  // Older word sits in the low half so bit 0 of the window is the earliest bit.
  assign window = {hs_data, hs_prev_q};

  // Previous word and locked offset; offset is only loaded on the lock cycle.
  always_ff @(posedge byte_clk) begin
    if (byte_rst) begin
      hs_prev_q <= '0;
      offset_q  <= '0;
    end else begin
      hs_prev_q <= hs_data;
      if (offset_load) begin
        offset_q <= match_off;
      end
    end
  end

  // Priority encoder: lowest bit offset whose candidate equals the sync byte wins.
  always_comb begin
    sync_found = 1'b0;
    match_off  = '0;
    for (int k = 0; k < 8; k++) begin
      if (!sync_found && (window[k +: 8] == SYNC_BYTE)) begin
        sync_found = 1'b1;
        match_off  = 3'(k);
      end
    end
  end

  // Barrel select of the aligned byte at the locked offset.
  always_comb begin
    shifted = window >> offset_q;
    aligned = shifted[7:0];
  end

endmodule

// File: rtl/dphy_rx_lane.sv
// Single-lane MIPI D-PHY receive data lane in the byte-clock domain: LP filtering,
// start-of-transmission sequencing, termination control, sync hunt and payload delivery.
module dphy_rx_lane
  import dphy_pkg::*;
#(
  parameter int unsigned LP_FILT      = 2,   // 1..15
  parameter int unsigned TERM_DLY     = 4,   // >= 1
  parameter int unsigned SYNC_TIMEOUT = 64,  // >= 1
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic       byte_clk,
  input  logic       byte_rst,
  input  logic       lp_p,
  input  logic       lp_n,
  input  logic [7:0] hs_data,
  output logic       hs_term_en,
  output logic [7:0] data,
  output logic       valid,
  output logic       sot,
  output logic       eot,
  output logic       err_sync,
  output logic       lane_idle
);

  localparam int unsigned     TmrW     = 16;
  localparam logic [3:0]      FiltLen  = 4'(LP_FILT);
  localparam logic [TmrW-1:0] TermLast = TmrW'(TERM_DLY - 1);
  localparam logic [TmrW-1:0] SyncLast = TmrW'(SYNC_TIMEOUT - 1);

  lane_state_e     state_q, state_d;
  logic [1:0]      lp_raw;
  logic [1:0]      lp_cand_q, lp_cand_d;
  logic [1:0]      lp_f_q, lp_f_d;
  logic [3:0]      filt_cnt_q, filt_cnt_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            hs_first_q, hs_first_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            sot_q, sot_d;
  logic            eot_q, eot_d;
  logic            err_q, err_d;
  logic            sync_found;
  logic [7:0]      aligned;

  assign lp_raw = {lp_p, lp_n};

  // LP filter next state: lp_f follows the raw code only once it has held LP_FILT samples.
  always_comb begin
    lp_cand_d = lp_raw;
    if (lp_raw != lp_cand_q) begin
      filt_cnt_d = 4'd1;
    end else if (filt_cnt_q < FiltLen) begin
      filt_cnt_d = filt_cnt_q + 4'd1;
    end else begin
      filt_cnt_d = filt_cnt_q;
    end
    lp_f_d = (filt_cnt_d >= FiltLen) ? lp_raw : lp_f_q;
  end

  // LP filter state; the line idles at LP-11 out of reset.
  always_ff @(posedge byte_clk) begin
    if (byte_rst) begin
      lp_cand_q  <= LP11;
      lp_f_q     <= LP11;
      filt_cnt_q <= '0;
    end else begin
      lp_cand_q  <= lp_cand_d;
      lp_f_q     <= lp_f_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Lane state register.
  always_ff @(posedge byte_clk) begin
    if (byte_rst) begin
      state_q <= StStop;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; LP transitions are checked before sync lock or timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStop: begin
        case (lp_f_q)
          LP01:       state_d = StHsRqst;
          LP10, LP00: state_d = StWaitStop;
          default:    state_d = StStop;
        endcase
      end
      StHsRqst: begin
        case (lp_f_q)
          LP00:    state_d = StBridge;
          LP11:    state_d = StStop;
          LP10:    state_d = StWaitStop;
          default: state_d = StHsRqst;
        endcase
      end
      StBridge: begin
        if (lp_f_q == LP11)         state_d = StStop;
        else if (tmr_q == TermLast) state_d = StSync;
      end
      StSync: begin
        if (lp_f_q == LP11)         state_d = StStop;
        else if (sync_found)        state_d = StHs;
        else if (tmr_q == SyncLast) state_d = StWaitStop;
      end
      StHs: begin
        if (lp_f_q == LP11) state_d = StStop;
      end
      StWaitStop: begin
        if (lp_f_q == LP11) state_d = StStop;
      end
      default: state_d = StStop;
    endcase
  end

  // State outputs and next values of the registered datapath outputs.
  always_comb begin
    hs_term_en = (state_q == StBridge) || (state_q == StSync) || (state_q == StHs);
    lane_idle  = (state_q == StStop);
    valid_d    = (state_q == StHs) && (lp_f_q != LP11);
    sot_d      = valid_d && hs_first_q;
    eot_d      = (state_q == StHs) && (lp_f_q == LP11);
    err_d      = (state_q == StSync) && (state_d == StWaitStop);
    hs_first_d = (state_q == StSync) && (state_d == StHs);
    data_d     = valid_d ? aligned : '0;
    // Cycle counter restarts on every state change and only runs in BRIDGE and SYNC.
    if (state_d != state_q) begin
      tmr_d = '0;
    end else if ((state_q == StBridge) || (state_q == StSync)) begin
      tmr_d = tmr_q + TmrW'(1);
    end else begin
      tmr_d = '0;
    end
  end

  // Registered payload, markers, timer and first-byte flag.
  always_ff @(posedge byte_clk) begin
    if (byte_rst) begin
      tmr_q      <= '0;
      hs_first_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sot_q      <= 1'b0;
      eot_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tmr_q      <= tmr_d;
      hs_first_q <= hs_first_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sot_q      <= sot_d;
      eot_q      <= eot_d;
      err_q      <= err_d;
    end
  end

  dphy_rx_align #(
    .SYNC_BYTE (SYNC_BYTE)
  ) u_align (
    .byte_clk    (byte_clk),
    .byte_rst    (byte_rst),
    .hs_data     (hs_data),
    .offset_load (hs_first_d),
    .sync_found  (sync_found),
    .aligned     (aligned)
  );

  assign data     = data_q;
  assign valid    = valid_q;
  assign sot      = sot_q;
  assign eot      = eot_q;
  assign err_sync = err_q;

endmodule

// File: tb/tb_dphy_rx_lane.sv
// Scenario bench for dphy_rx_lane: payload bytes are taken from a bit-stream model
// and queued as each stream is built, then popped as the lane presents valid bytes.
module tb_dphy_rx_lane;

  localparam int unsigned TermDly     = 4;
  localparam int unsigned SyncTimeout = 64;
  localparam logic [7:0]  SyncByte    = 8'hB8;

  logic       byte_clk = 1'b0;
  logic       byte_rst = 1'b1;
  logic       lp_p = 1'b1;
  logic       lp_n = 1'b1;
  logic [7:0] hs_data = '0;
  logic       hs_term_en, valid, sot, eot, err_sync, lane_idle;
  logic [7:0] data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pay[4];
  logic [255:0] stream;
  bit mon_en = 1'b0;
  int n_valid, n_sot, n_eot, n_err, sot_cyc, err_cyc, term_cyc;
  bit term_seen, idle_drop, valid_gap, eot_with_valid, valid_prev;

  dphy_rx_lane #(
    .LP_FILT      (2),
    .TERM_DLY     (TermDly),
    .SYNC_TIMEOUT (SyncTimeout),
    .SYNC_BYTE    (SyncByte)
  ) dut (
    .byte_clk   (byte_clk),
    .byte_rst   (byte_rst),
    .lp_p       (lp_p),
    .lp_n       (lp_n),
    .hs_data    (hs_data),
    .hs_term_en (hs_term_en),
    .data       (data),
    .valid      (valid),
    .sot        (sot),
    .eot        (eot),
    .err_sync   (err_sync),
    .lane_idle  (lane_idle)
  );

  always #5 byte_clk = ~byte_clk;

  always @(posedge byte_clk) cyc = cyc + 1;

  // Monitor: scoreboard pops on valid bytes and event bookkeeping, away from the edge.
  always @(negedge byte_clk) begin
    logic [7:0] want;
    if (valid) begin
      n_valid++;
      if (mon_en) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_data: got byte %02h, want none (scoreboard empty)", data);
        end else begin
          want = exp_q.pop_front();
          if (data !== want) $display("FAIL sb_data: got %02h want %02h", data, want);
          else n_pass++;
        end
      end
    end
    if (sot) begin
      n_sot++;
      if (n_sot == 1) sot_cyc = cyc;
    end
    if (eot) n_eot++;
    if (eot && valid) eot_with_valid = 1'b1;
    if (valid_prev && !valid && !eot) valid_gap = 1'b1;
    valid_prev = valid;
    if (err_sync) begin
      n_err++;
      err_cyc = cyc;
    end
    if (hs_term_en && !term_seen) begin
      term_seen = 1'b1;
      term_cyc  = cyc;
    end
    if (!lane_idle) idle_drop = 1'b1;
  end

  task automatic clear_mon();
    n_valid = 0; n_sot = 0; n_eot = 0; n_err = 0;
    sot_cyc = -1; err_cyc = -1; term_cyc = -1;
    term_seen = 1'b0; idle_drop = 1'b0; valid_gap = 1'b0;
    eot_with_valid = 1'b0; valid_prev = 1'b0;
  endtask

  task automatic drive(input logic [1:0] lp, input logic [7:0] hs);
    {lp_p, lp_n} = lp;
    hs_data = hs;
    @(posedge byte_clk);
    #1;
  endtask

  task automatic hold(input logic [1:0] lp, input int n);
    for (int i = 0; i < n; i++) drive(lp, 8'h00);
  endtask

  // Sync byte at bit offset off, then npay payload bytes; queue every following stream byte.
  task automatic build_stream(input int off, input int npay);
    stream = '0;
    stream[off +: 8] = SyncByte;
    for (int j = 0; j < npay; j++) stream[off + 8 + 8 * j +: 8] = pay[j];
    exp_q.delete();
    for (int b = off + 8; b + 8 <= 256; b += 8) exp_q.push_back(stream[b +: 8]);
  endtask

  task automatic test_reset();
    byte_rst = 1'b1;
    hold(2'b11, 3);
    n_checks++;
    if ({data, valid, sot, eot, err_sync, hs_term_en, lane_idle} !== {8'h00, 6'b000001})
      $display("FAIL reset_outputs: got %h want %h",
               {data, valid, sot, eot, err_sync, hs_term_en, lane_idle}, {8'h00, 6'b000001});
    else n_pass++;
    byte_rst = 1'b0;
    hold(2'b11, 4);
    n_checks++;
    if ({hs_term_en, lane_idle} !== 2'b01)
      $display("FAIL reset_idle: got %b want 01", {hs_term_en, lane_idle});
    else n_pass++;
  endtask

  task automatic test_sot(input int off, input int npay, input string tag);
    int e_first;
    int i;
    clear_mon();
    build_stream(off, npay);
    mon_en = 1'b1;
    hold(2'b11, 3);
    hold(2'b01, 3);
    hold(2'b00, 12);
    e_first = -1;
    for (i = 0; i < 12; i++) begin
      drive(2'b00, stream[8 * i +: 8]);
      if (i == 0) e_first = cyc;
    end
    // Stream keeps flowing during HS-trail while LP-11 is being filtered.
    while (n_eot == 0 && i < 31) begin
      drive(2'b11, stream[8 * i +: 8]);
      i++;
    end
    hold(2'b11, 3);
    mon_en = 1'b0;
    n_checks++;
    if (sot_cyc != e_first + 2)
      $display("FAIL %s_sot_cycle: got %0d want %0d", tag, sot_cyc, e_first + 2);
    else n_pass++;
    n_checks++;
    if (n_sot != 1) $display("FAIL %s_sot_count: got %0d want 1", tag, n_sot);
    else n_pass++;
    n_checks++;
    if (n_valid < npay) $display("FAIL %s_payload: got %0d bytes want >=%0d", tag, n_valid, npay);
    else n_pass++;
    n_checks++;
    if (n_eot != 1) $display("FAIL %s_eot_count: got %0d want 1", tag, n_eot);
    else n_pass++;
    n_checks++;
    if (eot_with_valid || valid_gap)
      $display("FAIL %s_valid_shape: got eot_with_valid=%0d gap=%0d want 0,0", tag,
               eot_with_valid, valid_gap);
    else n_pass++;
    n_checks++;
    if ({hs_term_en, lane_idle, valid, n_err != 0} !== 4'b0100)
      $display("FAIL %s_end_state: got %b want 0100", tag,
               {hs_term_en, lane_idle, valid, n_err != 0});
    else n_pass++;
  endtask

  task automatic test_timeout();
    int e0;
    int n;
    clear_mon();
    hold(2'b11, 3);
    hold(2'b01, 3);
    drive(2'b00, 8'h00);
    e0 = cyc;
    n = 0;
    while (n_err == 0 && n < 100) begin
      drive(2'b00, 8'h00);
      n++;
    end
    n_checks++;
    if (term_cyc != e0 + 2) $display("FAIL to_term_on: got %0d want %0d", term_cyc, e0 + 2);
    else n_pass++;
    n_checks++;
    if (err_cyc != e0 + 2 + TermDly + SyncTimeout)
      $display("FAIL to_err_cycle: got %0d want %0d", err_cyc, e0 + 2 + TermDly + SyncTimeout);
    else n_pass++;
    n_checks++;
    if ({hs_term_en, lane_idle} !== 2'b00)
      $display("FAIL to_term_off: got %b want 00", {hs_term_en, lane_idle});
    else n_pass++;
    hold(2'b00, 5);
    n_checks++;
    if (n_err != 1 || n_valid != 0 || lane_idle !== 1'b0)
      $display("FAIL to_wait: got err=%0d valid=%0d idle=%b want 1,0,0", n_err, n_valid,
               lane_idle);
    else n_pass++;
    hold(2'b11, 4);
    n_checks++;
    if (lane_idle !== 1'b1) $display("FAIL to_stop: got idle=%b want 1", lane_idle);
    else n_pass++;
  endtask

  task automatic test_glitch();
    clear_mon();
    hold(2'b11, 4);
    drive(2'b01, 8'h00);
    hold(2'b11, 6);
    n_checks++;
    if (idle_drop || term_seen)
      $display("FAIL glitch: got idle_drop=%0d term=%0d want 0,0", idle_drop, term_seen);
    else n_pass++;
  endtask

  task automatic test_abort();
    clear_mon();
    hold(2'b11, 3);
    hold(2'b01, 3);
    hold(2'b11, 6);
    n_checks++;
    if (!idle_drop || term_seen || lane_idle !== 1'b1)
      $display("FAIL abort: got left_stop=%0d term=%0d idle=%b want 1,0,1", idle_drop,
               term_seen, lane_idle);
    else n_pass++;
    hold(2'b10, 4);
    n_checks++;
    if (lane_idle !== 1'b0) $display("FAIL esc_wait: got idle=%b want 0", lane_idle);
    else n_pass++;
    hold(2'b10, 4);
    n_checks++;
    if (lane_idle !== 1'b0) $display("FAIL esc_hold: got idle=%b want 0", lane_idle);
    else n_pass++;
    hold(2'b11, 4);
    n_checks++;
    if (lane_idle !== 1'b1 || term_seen)
      $display("FAIL esc_stop: got idle=%b term=%0d want 1,0", lane_idle, term_seen);
    else n_pass++;
  endtask

  task automatic test_rst_mid_hs();
    int i;
    clear_mon();
    build_stream(0, 3);
    mon_en = 1'b1;
    hold(2'b11, 3);
    hold(2'b01, 3);
    hold(2'b00, 12);
    i = 0;
    while (valid !== 1'b1 && i < 12) begin
      drive(2'b00, stream[8 * i +: 8]);
      i++;
    end
    n_checks++;
    if (valid !== 1'b1) $display("FAIL rst_reach_hs: got valid=%b want 1", valid);
    else n_pass++;
    byte_rst = 1'b1;
    drive(2'b11, 8'h00);
    n_checks++;
    if ({data, valid, sot, eot, err_sync, hs_term_en, lane_idle} !== {8'h00, 6'b000001})
      $display("FAIL rst_mid_hs: got %h want %h",
               {data, valid, sot, eot, err_sync, hs_term_en, lane_idle}, {8'h00, 6'b000001});
    else n_pass++;
    byte_rst = 1'b0;
    mon_en = 1'b0;
    hold(2'b11, 5);
    n_checks++;
    if (n_eot != 0) $display("FAIL rst_no_eot: got %0d eot want 0", n_eot);
    else n_pass++;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    test_reset();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h00;
    test_sot(0, 3, "off0");
    pay[0] = 8'hA5; pay[1] = 8'h5A; pay[2] = 8'h00; pay[3] = 8'h00;
    test_sot(3, 2, "off3");
    pay[0] = 8'h3C; pay[1] = 8'hC3; pay[2] = 8'h96; pay[3] = 8'h69;
    test_sot(7, 4, "off7");
    test_timeout();
    test_glitch();
    test_abort();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h00;
    test_rst_mid_hs();
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    test_sot(0, 4, "after_rst");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dphy_rx_lane.md
Name: dphy_rx_lane

Overview:
- Single-lane MIPI D-PHY receive data lane, byte-clock domain; the receive counterpart of the team's transmit data lane.
- Inputs: the lane's LP line levels (already synchronised to byte_clk) and raw, unaligned 8-bit words from an external 1:8 deserialiser.
- Function: detects start-of-transmission, controls HS termination, hunts for the sync byte, bit-aligns, and delivers payload bytes with sot/eot markers to the packet layer.

Parameters:
- LP_FILT, 2: consecutive cycles an LP state must hold before it is accepted (1..15).
- TERM_DLY, 4: cycles in LP-00 with hs_term_en high before sync search starts.
- SYNC_TIMEOUT, 64: maximum sync-search cycles before err_sync.
- SYNC_BYTE, 8'hB8: sync pattern as it appears LSB-first in the deserialised word.

Ports:
- byte_clk  in  1  byte clock; all logic on rising edge.
- byte_rst  in  1  reset, synchronous, active-high.
- lp_p  in  1  LP Dp level.
- lp_n  in  1  LP Dn level.
- hs_data  in  8  raw deserialised HS word; bit 0 is the earliest received bit.
- hs_term_en  out  1  enables the HS receiver/termination.
- data  out  8  aligned payload byte.
- valid  out  1  data is valid this cycle.
- sot  out  1  coincides with valid on the first payload byte.
- eot  out  1  one-cycle pulse after the last payload byte.
- err_sync  out  1  one-cycle pulse on sync timeout.
- lane_idle  out  1  high in STOP.

Behaviour:
- Reset: state STOP. data=0, valid=0, sot=0, eot=0, err_sync=0, hs_term_en=0, lane_idle=1. Filter counter, window and offset cleared.
- LP filter: raw {lp_p,lp_n} must be stable for LP_FILT cycles before the filtered state lp_f updates. Any change restarts the count. The FSM sees only lp_f.
- STOP: lp_f=01 -> HS_RQST. lp_f=10 (escape, not supported) -> WAIT_STOP. 00 -> WAIT_STOP.
- HS_RQST: lp_f=00 -> BRIDGE, hs_term_en=1 from the next cycle. lp_f=11 -> STOP. lp_f=10 -> WAIT_STOP.
- BRIDGE: count TERM_DLY cycles -> SYNC. lp_f=11 at any point -> STOP with hs_term_en=0.
- SYNC:
  - Window w = {hs_data, hs_prev}, 16 bits; hs_prev is the previous cycle's hs_data.
  - Candidate k is w[k+7:k], k=0..7. Lock the lowest k whose candidate equals SYNC_BYTE -> HS.
  - Timeout counter reaches SYNC_TIMEOUT -> err_sync pulse, hs_term_en=0, -> WAIT_STOP.
  - lp_f=11 -> STOP, no eot.
- HS:
  - Each cycle output data=w[k+7:k], registered.
  - Sync located at cycle n: first payload byte has valid=1 and sot=1 at cycle n+2. valid stays high every subsequent cycle.
  - lp_f=11 -> valid=0 and eot=1 next cycle, hs_term_en=0, -> STOP.
  - Bytes received during HS-trail and the LP_FILT delay are delivered. Trailer stripping is the packet layer's job.
- WAIT_STOP: outputs idle; lp_f=11 -> STOP.
- Simultaneous events: an LP transition takes priority over sync detection or timeout in the same cycle.
- byte_rst mid-packet: immediate return to reset values; no eot issued.

Decomposition:
- Package dphy_pkg: lane state enum (STOP, HS_RQST, BRIDGE, SYNC, HS, WAIT_STOP), LP code constants (LP11=2'b11, LP01, LP00, LP10), SYNC_BYTE default.
- Sub-module dphy_rx_align: window register, offset search (priority encoder) and barrel-select mux.
- FSM and LP filter stay in the top module.

Test Plan:
- Clean SoT, offset 0: LP 11->01->00 each held 3 cycles; hs_data=B8 then 11,22,33; then LP-11. Expect sot+valid with data=11 two cycles after the B8 cycle, then 22, 33; eot pulse after LP-11 is filtered; lane_idle=1.
- Offset 3: hs_data words carrying 0xB8 shifted left 3 bits across a word boundary, then payload A5,5A. Expect lock k=3 and output A5,5A.
- Sync timeout: enter HS, hs_data=00 for 64 cycles. Expect err_sync one pulse, hs_term_en=0; no valid until LP-11 then STOP.
- Glitch rejection: 1-cycle LP-01 blip in STOP with LP_FILT=2. Expect state stays STOP and hs_term_en stays 0.
- Abort: LP 11->01->11. Expect return to STOP with hs_term_en never asserted. Separately, LP-10 from STOP -> WAIT_STOP until LP-11.
- Reset mid-HS: assert byte_rst while valid=1. Expect all outputs at reset values next cycle, no eot; the next SoT is received correctly.
